// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, branch flush control and saturating hazard counters.
// Latency: ID fields appear on IDEX_* one cycle after an advance; PC_write/IFID_write/IFID_flush are combinational.
// Backpressure: ext_stall freezes everything; load-use inserts one bubble while holding PC and IF/ID.
module idex_hazard_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_valid,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic [XLEN-1:0]  ID_rs1_data,
    input  logic [XLEN-1:0]  ID_rs2_data,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [3:0]       ID_funct,
    input  logic             ID_RegWrite,
    input  logic             ID_MemtoReg,
    input  logic             ID_MemRead,
    input  logic             ID_MemWrite,
    input  logic             ID_Branch,
    input  logic             ID_ALUSrc,
    input  logic [1:0]       ID_ALUOp,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic [XLEN-1:0]  IDEX_pc,
    output logic [XLEN-1:0]  IDEX_rs1_data,
    output logic [XLEN-1:0]  IDEX_rs2_data,
    output logic [XLEN-1:0]  IDEX_imm,
    output logic [4:0]       IDEX_rs1,
    output logic [4:0]       IDEX_rs2,
    output logic [4:0]       IDEX_rd,
    output logic [3:0]       IDEX_funct,
    output logic             IDEX_RegWrite,
    output logic             IDEX_MemtoReg,
    output logic             IDEX_MemRead,
    output logic             IDEX_MemWrite,
    output logic             IDEX_Branch,
    output logic             IDEX_ALUSrc,
    output logic [1:0]       IDEX_ALUOp,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        logic [1:0]      alu_op;
    } idex_t;

    typedef enum logic [1:0] {
        MODE_ADVANCE,
        MODE_HOLD,
        MODE_FLUSH,
        MODE_STALL
    } mode_t;

    idex_t idex_q;
    idex_t id_dat;
    mode_t mode;
    logic  load_use;

    assign id_dat = '{
        pc:         ID_pc,
        rs1_data:   ID_rs1_data,
        rs2_data:   ID_rs2_data,
        imm:        ID_imm,
        rs1:        ID_rs1,
        rs2:        ID_rs2,
        rd:         ID_rd,
        funct:      ID_funct,
        reg_write:  ID_RegWrite,
        mem_to_reg: ID_MemtoReg,
        mem_read:   ID_MemRead,
        mem_write:  ID_MemWrite,
        branch:     ID_Branch,
        alu_src:    ID_ALUSrc,
        alu_op:     ID_ALUOp
    };

    // A load into x0 never creates a dependency, so rd==0 is excluded.
    assign load_use = idex_q.mem_read & ID_valid & (idex_q.rd != 5'd0) &
                      ((idex_q.rd == ID_rs1) | (idex_q.rd == ID_rs2));

    always_comb begin
        mode       = MODE_ADVANCE;
        PC_write   = 1'b1;
        IFID_write = 1'b1;
        IFID_flush = 1'b0;
        if (ext_stall) begin
            mode       = MODE_HOLD;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
        end else if (branch_taken) begin
            mode       = MODE_FLUSH;
            IFID_flush = 1'b1;
        end else if (load_use) begin
            mode       = MODE_STALL;
            PC_write   = 1'b0;
            IFID_write = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q      <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            unique case (mode)
                MODE_HOLD: idex_q <= idex_q;
                MODE_FLUSH: begin
                    idex_q <= '0;
                    if (flush_count != {CNT_W{1'b1}})
                        flush_count <= flush_count + 1'b1;
                end
                MODE_STALL: begin
                    idex_q <= '0;
                    if (stall_count != {CNT_W{1'b1}})
                        stall_count <= stall_count + 1'b1;
                end
                default: idex_q <= ID_valid ? id_dat : '0;
            endcase
        end
    end

    assign IDEX_pc       = idex_q.pc;
    assign IDEX_rs1_data = idex_q.rs1_data;
    assign IDEX_rs2_data = idex_q.rs2_data;
    assign IDEX_imm      = idex_q.imm;
    assign IDEX_rs1      = idex_q.rs1;
    assign IDEX_rs2      = idex_q.rs2;
    assign IDEX_rd       = idex_q.rd;
    assign IDEX_funct    = idex_q.funct;
    assign IDEX_RegWrite = idex_q.reg_write;
    assign IDEX_MemtoReg = idex_q.mem_to_reg;
    assign IDEX_MemRead  = idex_q.mem_read;
    assign IDEX_MemWrite = idex_q.mem_write;
    assign IDEX_Branch   = idex_q.branch;
    assign IDEX_ALUSrc   = idex_q.alu_src;
    assign IDEX_ALUOp    = idex_q.alu_op;

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Randomized bench for idex_hazard_stage against a rule-level reference model (small counters to reach saturation).
module tb_idex_hazard_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ID_valid;
    logic [XLEN-1:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic [3:0] ID_funct;
    logic ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc;
    logic [1:0] ID_ALUOp;
    logic branch_taken, ext_stall;
    logic [XLEN-1:0] IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm;
    logic [4:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [3:0] IDEX_funct;
    logic IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite, IDEX_Branch, IDEX_ALUSrc;
    logic [1:0] IDEX_ALUOp;
    logic PC_write, IFID_write, IFID_flush;
    logic [CNT_W-1:0] stall_count, flush_count;

    idex_hazard_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_pc(ID_pc),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
        .ID_funct(ID_funct), .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_Branch(ID_Branch),
        .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp), .branch_taken(branch_taken),
        .ext_stall(ext_stall), .IDEX_pc(IDEX_pc), .IDEX_rs1_data(IDEX_rs1_data),
        .IDEX_rs2_data(IDEX_rs2_data), .IDEX_imm(IDEX_imm), .IDEX_rs1(IDEX_rs1),
        .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd), .IDEX_funct(IDEX_funct),
        .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemtoReg(IDEX_MemtoReg),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
        .IDEX_Branch(IDEX_Branch), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUOp(IDEX_ALUOp),
        .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc, a, b, imm;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] funct;
        logic rw, m2r, mr, mw, br, as;
        logic [1:0] op;
    } rec_t;

    rec_t m_q;
    int   m_stall, m_flush;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic rec_t id_rec();
        return '{ID_pc, ID_rs1_data, ID_rs2_data, ID_imm, ID_rs1, ID_rs2, ID_rd, ID_funct,
                 ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc, ID_ALUOp};
    endfunction

    function automatic rec_t dut_rec();
        return '{IDEX_pc, IDEX_rs1_data, IDEX_rs2_data, IDEX_imm, IDEX_rs1, IDEX_rs2, IDEX_rd,
                 IDEX_funct, IDEX_RegWrite, IDEX_MemtoReg, IDEX_MemRead, IDEX_MemWrite,
                 IDEX_Branch, IDEX_ALUSrc, IDEX_ALUOp};
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? CMAX : c + 1;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        ID_valid = 0; ID_pc = '0; ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
        ID_rs1_data = '0; ID_rs2_data = '0; ID_imm = '0; ID_funct = 0;
        ID_RegWrite = 0; ID_MemtoReg = 0; ID_MemRead = 0; ID_MemWrite = 0;
        ID_Branch = 0; ID_ALUSrc = 0; ID_ALUOp = 0; branch_taken = 0; ext_stall = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        set_idle();
        ID_valid = 1; ID_rd = rd; ID_MemRead = 1; ID_MemtoReg = 1; ID_RegWrite = 1;
        ID_ALUSrc = 1; ID_pc = 32'h100; ID_imm = 32'h8;
    endtask

    // Inputs are set just after a falling edge; one call covers one rising edge.
    task automatic cycle();
        logic lu;
        logic [2:0] exp_ctl;
        #1;
        lu = m_q.mr && ID_valid && (m_q.rd != 0) && ((m_q.rd == ID_rs1) || (m_q.rd == ID_rs2));
        if (ext_stall)         exp_ctl = 3'b000;
        else if (branch_taken) exp_ctl = 3'b111;
        else if (lu)           exp_ctl = 3'b000;
        else                   exp_ctl = 3'b110;
        chk("ctl", {PC_write, IFID_write, IFID_flush}, exp_ctl);
        if (!ext_stall) begin
            if (branch_taken) begin
                m_q = '0; m_flush = sat_inc(m_flush);
            end else if (lu) begin
                m_q = '0; m_stall = sat_inc(m_stall);
            end else begin
                m_q = ID_valid ? id_rec() : '0;
            end
        end
        @(posedge clk); #1;
        chk("idex", dut_rec(), m_q);
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        @(negedge clk);
    endtask

    // Called right after a falling edge; reset must act without any clock edge.
    task automatic async_reset();
        #1 rst_n = 0;
        #1;
        chk("rst_idex", dut_rec(), '0);
        chk("rst_cnt", {stall_count, flush_count}, '0);
        m_q = '0; m_stall = 0; m_flush = 0;
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 1;
        set_idle();
        m_q = '0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        async_reset();

        // Reset then advance
        ID_valid = 1; ID_rd = 5; ID_RegWrite = 1; ID_pc = 32'h40;
        cycle();
        chk("adv_rd", IDEX_rd, 5);
        chk("adv_regwrite", IDEX_RegWrite, 1);
        chk("adv_pc", IDEX_pc, 32'h40);

        // Load-use on rs2
        set_load(7); cycle();
        set_idle(); ID_valid = 1; ID_rs1 = 2; ID_rs2 = 7; ID_rd = 8; ID_RegWrite = 1;
        cycle();
        chk("lu_bubble", {IDEX_rd, IDEX_MemRead, IDEX_RegWrite}, 0);
        chk("lu_stall_count", stall_count, 1);
        cycle();
        chk("lu_add_rd", IDEX_rd, 8);

        // Load into x0: no stall
        set_load(0); cycle();
        set_idle(); ID_valid = 1; ID_rs1 = 0; ID_rd = 3; cycle();
        chk("x0_stall_count", stall_count, 1);

        // Flush wins over load-use
        set_load(7); cycle();
        set_idle(); ID_valid = 1; ID_rs1 = 7; branch_taken = 1; cycle();
        chk("flush_count", flush_count, 1);
        chk("flush_stall_count", stall_count, 1);

        // Freeze during load-use, then the stall proceeds
        set_load(9); cycle();
        set_idle(); ID_valid = 1; ID_rs1 = 9; ID_rd = 4; ext_stall = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("hold_rd", IDEX_rd, 9);
        ext_stall = 0; cycle(); cycle();

        // Saturation
        for (int i = 0; i < 5; i++) begin
            set_load(3); cycle();
            set_idle(); ID_valid = 1; ID_rs2 = 3; cycle();
        end
        chk("sat_stall_count", stall_count, CMAX);

        async_reset();
        set_idle();
        for (int i = 0; i < 3000; i++) begin
            ID_valid     = ($urandom % 4) != 0;
            ID_pc        = $urandom; ID_rs1_data = $urandom; ID_rs2_data = $urandom;
            ID_imm       = $urandom; ID_funct = 4'($urandom);
            ID_rs1       = 5'($urandom_range(0, 3));
            ID_rs2       = 5'($urandom_range(0, 3));
            ID_rd        = 5'($urandom_range(0, 3));
            {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc} = 6'($urandom);
            ID_ALUOp     = 2'($urandom);
            branch_taken = ($urandom % 10) == 0;
            ext_stall    = ($urandom % 8) == 0;
            if (($urandom % 150) == 0) async_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
